// File: rtl/cpu_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_div_pkg
//  Description : Shared types, sizes and sign helper for the iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_div_pkg;

    localparam int c_DIV_WIDTH = 32;
    localparam int c_DIV_CNT_W = 5;
    // Working width of cond_neg; callers zero-extend and keep the low bits.
    localparam int c_NEG_W     = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_t;

    function automatic logic [c_NEG_W-1:0] cond_neg(input logic [c_NEG_W-1:0] v,
                                                    input logic               neg);
        return neg ? (~v + c_NEG_W'(1)) : v;
    endfunction

endpackage : cpu_div_pkg
`default_nettype wire

// File: rtl/cpu_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_div_step
//  Description : One radix-2 restoring iteration: shift, trial subtract, select.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_div_step
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = c_DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_prem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_prem_next,
    output logic             o_q_bit
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_trial;
    logic             w_unused_msb;

    assign w_unused_msb = i_prem[WIDTH];
    assign w_shifted    = {i_prem[WIDTH-1:0], i_dvd_bit};
    // One extra bit so the borrow is visible even when w_shifted uses its top bit.
    assign w_trial      = {1'b0, w_shifted} - {2'b00, i_dvs};
    assign o_q_bit      = ~w_trial[WIDTH+1];
    assign o_prem_next  = o_q_bit ? w_trial[WIDTH:0] : w_shifted;

endmodule : cpu_div_step
`default_nettype wire

// File: rtl/cpu_div_cell.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_div_cell
//  Description : Iterative radix-2 restoring divider for DIV/DIVU, WIDTH+2 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_div_cell
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = c_DIV_WIDTH,
    parameter int CNT_W = c_DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic             E_div_start,
    input  logic             E_div_signed,
    input  logic             ena,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_prem;
    logic             r_signed;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz_out;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic [WIDTH:0]   w_prem_next;
    logic             w_q_bit;
    logic [c_NEG_W-1:0] w_abs_dvd;
    logic [c_NEG_W-1:0] w_abs_dvs;
    logic [c_NEG_W-1:0] w_fix_q;
    logic [c_NEG_W-1:0] w_fix_r;
    logic               w_unused_neg;

    assign w_abs_dvd = cond_neg(c_NEG_W'(r_dvd), r_signed & r_dvd[WIDTH-1]);
    assign w_abs_dvs = cond_neg(c_NEG_W'(r_dvs), r_signed & r_dvs[WIDTH-1]);
    assign w_fix_q   = cond_neg(c_NEG_W'(r_dvd), r_neg_q);
    assign w_fix_r   = cond_neg(c_NEG_W'(r_prem[WIDTH-1:0]), r_neg_r);
    assign w_unused_neg = ^{w_abs_dvd[c_NEG_W-1:WIDTH], w_abs_dvs[c_NEG_W-1:WIDTH],
                            w_fix_q[c_NEG_W-1:WIDTH], w_fix_r[c_NEG_W-1:WIDTH]};

    cpu_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_prem      (r_prem),
        .i_dvd_bit   (r_dvd[WIDTH-1]),
        .i_dvs       (r_dvs),
        .o_prem_next (w_prem_next),
        .o_q_bit     (w_q_bit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_signed    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dbz       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz_out   <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (E_div_start) begin
                        r_dvd    <= E_src1;
                        r_dvs    <= E_src2;
                        r_signed <= E_div_signed;
                        r_neg_q  <= E_div_signed & (E_src1[WIDTH-1] ^ E_src2[WIDTH-1]);
                        r_neg_r  <= E_div_signed & E_src1[WIDTH-1];
                        r_dbz    <= (E_src2 == '0);
                        r_busy   <= 1'b1;
                        r_state  <= PREP;
                    end
                end
                PREP: begin
                    r_dvd   <= w_abs_dvd[WIDTH-1:0];
                    r_dvs   <= w_abs_dvs[WIDTH-1:0];
                    r_prem  <= '0;
                    r_cnt   <= '0;
                    r_state <= ITER;
                end
                ITER: begin
                    // Quotient bits enter at the LSB as dividend bits leave the MSB.
                    r_prem <= w_prem_next;
                    r_dvd  <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_quotient  <= w_fix_q[WIDTH-1:0];
                    r_remainder <= w_fix_r[WIDTH-1:0];
                    r_dbz_out   <= r_dbz;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end else begin
            r_done <= 1'b0;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz_out;

endmodule : cpu_div_cell
`default_nettype wire

// File: tb/tb_cpu_div_cell.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_div_cell
//  Description : Self-checking bench for cpu_div_cell with an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_div_cell;

    localparam int c_W   = 32;
    localparam int c_LAT = c_W + 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [c_W-1:0] E_src1 = '0;
    logic [c_W-1:0] E_src2 = '0;
    logic           E_div_start = 1'b0;
    logic           E_div_signed = 1'b0;
    logic           ena = 1'b1;
    logic           busy;
    logic           done;
    logic [c_W-1:0] quotient;
    logic [c_W-1:0] remainder;
    logic           div_by_zero;

    int errors = 0;
    int checks = 0;
    int n      = 0;
    int shown  = 0;

    cpu_div_cell #(.WIDTH(c_W), .CNT_W(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .E_src1       (E_src1),
        .E_src2       (E_src2),
        .E_div_start  (E_div_start),
        .E_div_signed (E_div_signed),
        .ena          (ena),
        .busy         (busy),
        .done         (done),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    // Result of a division from magnitudes and sign rules: {dbz, q, r}.
    function automatic logic [2*c_W:0] model_div(input logic [c_W-1:0] a,
                                                 input logic [c_W-1:0] b,
                                                 input logic           s);
        logic           na, nb;
        logic [c_W-1:0] ma, mb, qm, rm, q, r;
        na = s & a[c_W-1];
        nb = s & b[c_W-1];
        ma = na ? -a : a;
        mb = nb ? -b : b;
        if (b == '0) begin
            qm = '1;
            rm = ma;
        end else begin
            qm = ma / mb;
            rm = ma % mb;
        end
        q = (na ^ nb) ? -qm : qm;
        r = na ? -rm : rm;
        return {(b == '0), q, r};
    endfunction

    // Transaction-level model: a countdown of enabled cycles per accepted start.
    int             m_rem  = 0;
    logic           m_done = 1'b0;
    logic           m_dbz  = 1'b0;
    logic [c_W-1:0] m_q    = '0;
    logic [c_W-1:0] m_r    = '0;
    logic [2*c_W:0] m_pend = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rem = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dbz = 1'b0;
        end else if (ena) begin
            if (m_rem > 0) begin
                m_rem  = m_rem - 1;
                m_done = (m_rem == 0);
                if (m_rem == 0) {m_dbz, m_q, m_r} = m_pend;
            end else begin
                m_done = 1'b0;
                if (E_div_start) begin
                    m_rem  = c_LAT;
                    m_pend = model_div(E_src1, E_src2, E_div_signed);
                end
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        checks = checks + 1;
        if ({busy, done, quotient, remainder, div_by_zero} !==
            {(m_rem != 0), m_done, m_q, m_r, m_dbz}) begin
            errors = errors + 1;
            if (shown < 20)
                $display("FAIL cycle_cmp t=%0t busy=%b/%b done=%b/%b q=%h/%h r=%h/%h dbz=%b/%b (actual/required)",
                         $time, busy, (m_rem != 0), done, m_done, quotient, m_q,
                         remainder, m_r, div_by_zero, m_dbz);
            shown = shown + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        n = n + 1;
    endtask

    task automatic chk(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [c_W-1:0] a, input logic [c_W-1:0] b, input logic s);
        E_src1 = a; E_src2 = b; E_div_signed = s; E_div_start = 1'b1;
        tick();
        E_div_start = 1'b0;
        n = 0;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && n < 200) tick();
        if (done !== 1'b1) begin
            errors = errors + 1;
            checks = checks + 1;
            $display("FAIL done_timeout actual=no_done required=done");
        end
    endtask

    task automatic run(input string name, input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                       input logic s, input logic [c_W-1:0] eq, input logic [c_W-1:0] er,
                       input logic edbz);
        do_start(a, b, s);
        wait_done();
        chk({name, "_lat"}, n, c_LAT);
        chk({name, "_q"}, quotient, eq);
        chk({name, "_r"}, remainder, er);
        chk({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_q", quotient, 32'h0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'h0);
        reset_n = 1'b1;
        tick();

        run("u100_7",  32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0);
        run("s-100_7", 32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        run("s100_-7", 32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        1'b0);
        run("s-100_-7",32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0);
        run("dbz",     32'h1234,     32'h0,        1'b0, 32'hFFFFFFFF, 32'h1234,     1'b1);
        run("ovf",     32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0,        1'b0);
        repeat (3) tick();
        chk("hold_q", quotient, 32'h80000000);
        chk("hold_done", {31'd0, done}, 32'h0);

        // Freeze mid-iteration and pulse a start that must be ignored.
        do_start(32'd1000, 32'd10, 1'b0);
        repeat (10) tick();
        E_src1 = 32'd7; E_src2 = 32'd3; E_div_start = 1'b1;
        tick();
        E_div_start = 1'b0;
        ena = 1'b0;
        repeat (5) tick();
        chk("frozen_busy", {31'd0, busy}, 32'd1);
        ena = 1'b1;
        wait_done();
        chk("ena_lat", n, 32'd39);
        chk("ena_q", quotient, 32'd100);
        chk("ena_r", remainder, 32'd0);

        // Start coinciding with the done edge is not accepted.
        do_start(32'd53, 32'd5, 1'b0);
        while (n < c_LAT - 1) tick();
        E_src1 = 32'd9; E_src2 = 32'd2; E_div_start = 1'b1;
        tick();
        chk("fix_done", {31'd0, done}, 32'd1);
        E_div_start = 1'b0;
        tick();
        tick();
        chk("fix_start_ignored", {31'd0, busy}, 32'd0);
        chk("fix_q", quotient, 32'd10);
        chk("fix_r", remainder, 32'd3);

        // Reset around iteration 10 aborts the operation.
        do_start(32'hFFFF, 32'd3, 1'b0);
        repeat (11) tick();
        reset_n = 1'b0;
        #1;
        chk("arst_q", quotient, 32'h0);
        chk("arst_r", remainder, 32'h0);
        repeat (3) tick();
        chk("arst_busy_done", {30'd0, busy, done}, 32'h0);
        reset_n = 1'b1;
        tick();
        run("post_rst", 32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 1'b0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cpu_div_cell
`default_nettype wire

// File: doc/cpu_div_cell.md
Name: cpu_div_cell

Overview:
- Iterative radix-2 restoring divider for the CPU's DIV/DIVU instructions.
- Complements the three-partial-product multiplier cell in the execute/memory path.
- Accepts operands from the execute stage with a start pulse and computes quotient and remainder over a fixed number of cycles.
- Reports completion with a one-cycle done pulse and holds its results until the next start.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits; must be ≥ 4 and a power of 2.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- E_src1  input  WIDTH  dividend, sampled on an accepted start.
- E_src2  input  WIDTH  divisor, sampled on an accepted start.
- E_div_start  input  1  request a division; accepted only when busy=0 and ena=1.
- E_div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- ena  input  1  pipeline enable; while 0, all state and outputs are frozen.
- busy  output  1  high from the cycle after acceptance until the cycle done is asserted.
- done  output  1  one-cycle pulse when quotient, remainder and div_by_zero become valid.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  set with done when the sampled divisor was 0.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FSM goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
  - A reset in the middle of an operation aborts it; no done is produced.
- FSM states and transitions (each transition requires ena=1; otherwise the state holds):
  - IDLE: start → PREP.
  - PREP → ITER.
  - ITER with counter=WIDTH-1 → FIX.
  - FIX → IDLE, asserting done.
- IDLE:
  - On start, capture E_src1, E_src2, E_div_signed.
  - Record neg_q = signed & (src1[MSB] ^ src2[MSB]) and neg_r = signed & src1[MSB].
- PREP:
  - Replace each operand with its magnitude (two's-complement negate if signed and MSB set).
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
- ITER, once per enabled cycle:
  - trial = {prem[WIDTH-1:0], dvd[MSB]} − {1'b0, dvs}.
  - If trial is non-negative: prem=trial and shift 1 into the quotient LSB; otherwise prem is the shifted value and 0 is shifted in.
  - The dividend shifts left one bit; the counter increments.
  - Exactly WIDTH iterations.
- FIX:
  - quotient = neg_q ? −q : q.
  - remainder = neg_r ? −r : r (remainder sign follows the dividend).
  - Drive done=1 for that one cycle; outputs register on this edge.
- Latency: 1 (PREP) + WIDTH (ITER) + 1 (FIX), so done appears WIDTH+2 enabled cycles after the accepting edge (34 for WIDTH=32). The latency is constant for all operands.
- Divide by zero:
  - No special path; the iteration naturally yields all-ones magnitude and remainder = |dividend|, and FIX sign correction then applies.
  - div_by_zero=1 with done; latency unchanged.
- Signed overflow: MIN_INT / −1 gives quotient 0x8000_0000 and remainder 0 by wrap-around; no flag.
- Start while busy=1 is ignored; no queueing.
- Start in the same cycle as FIX (done high) is ignored; accepting requires state IDLE.
- Outputs and div_by_zero hold their values until the next FIX. They do not clear on a new start.
- When ena=0, done is not re-asserted: it is a pulse on the FIX edge only, and is held low while frozen in IDLE.

Decomposition:
- Shared package cpu_div_pkg holds:
  - state enum (IDLE, PREP, ITER, FIX)
  - WIDTH default and CNT_W
  - a negate/abs function used in PREP and FIX
- One natural sub-module, cpu_div_step: a combinational subtract/compare/shift for a single iteration.
  - Inputs: prem, dividend bit, divisor.
  - Outputs: new prem, quotient bit.
  - Kept separate so radix-4 can replace it later.

Test Plan:
- Unsigned 100 / 7, ena=1 → done at cycle 34 after accept; quotient=14, remainder=2, div_by_zero=0.
- Signed −100 / 7 → quotient=0xFFFF_FFF2 (−14), remainder=0xFFFF_FFFE (−2); signed 100 / −7 → quotient=−14, remainder=2.
- Divisor 0, unsigned dividend 0x1234 → div_by_zero=1; quotient=0xFFFF_FFFF, remainder=0x1234; latency still 34.
- Signed 0x8000_0000 / 0xFFFF_FFFF → quotient=0x8000_0000, remainder=0, div_by_zero=0.
- ena held low for 5 cycles mid-ITER and start pulsed while busy → done at cycle 39; result of the first operands only; second start ignored.
- reset_n asserted at iteration 10, then released and 0xFFFF_FFFF / 0x10 unsigned started → all outputs 0 during reset, no spurious done; then quotient=0x0FFF_FFFF, remainder=0xF.
